// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared TPU tile constants and weight reader state encoding
//
// Purpose: constants shared by the weight memory, the weight reader and the
//          systolic array, plus the weight reader FSM state type.
// Ports:   none (package)

package tpu_pkg;

    localparam int SIZE   = 8;               // array dimension (rows = cols)
    localparam int DATA_W = 5;               // weight width in bits
    localparam int ADDR_W = 6;               // log2(SIZE*SIZE)
    localparam int IDX_W  = $clog2(SIZE);    // row / column index width
    localparam int ROW_W  = SIZE * DATA_W;   // packed row width

    typedef enum logic [2:0] {
        WMR_IDLE   = 3'd0,
        WMR_FETCH  = 3'd1,
        WMR_DRAIN  = 3'd2,
        WMR_HOLD   = 3'd3,
        WMR_FINISH = 3'd4
    } wmr_state_t;

endpackage

// File: rtl/weight_mem_reader_row_assembler.sv
// rtl/weight_mem_reader_row_assembler.sv - packs captured column reads into one row word
//
// Purpose: holds the packed row register; on a capture strobe the incoming
//          weight is written into the slot of the given column, all other
//          slots (and the whole word when not capturing) hold their value.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset, clears the row
//   i_cap_en in   write i_data into slot i_col this cycle
//   i_col    in   column slot to write
//   i_data   in   weight value
//   o_row    out  packed row; column c at [c*DATA_W +: DATA_W]

module row_assembler
    import tpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cap_en,
    input  logic [IDX_W-1:0]  i_col,
    input  logic [DATA_W-1:0] i_data,
    output logic [ROW_W-1:0]  o_row
);

    logic [ROW_W-1:0] r_row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row <= '0;
        end else if (i_cap_en) begin
            r_row[i_col*DATA_W +: DATA_W] <= i_data;
        end
    end

    assign o_row = r_row;

endmodule

// File: rtl/weight_mem_reader.sv
// rtl/weight_mem_reader.sv - streams the 8x8 weight tile out of memory one packed row at a time
//
// Purpose: after preload, reads the weight memory row by row (highest row
//          first), packs each row into one word and offers it to the array
//          weight shift chain over a valid/ready handshake.
// Ports:
//   clk              in   clock, rising edge
//   rst              in   asynchronous active-high reset
//   i_preload_done   in   memory contents are final
//   i_start          in   one-cycle request to load the array
//   o_mem_rd_en      out  memory read strobe
//   o_mem_rd_addr    out  read address, row*SIZE+col
//   i_mem_rd_data    in   read data, one cycle after o_mem_rd_en
//   o_row_valid      out  o_row_data / o_row_idx valid
//   i_row_ready      in   array accepts the row this cycle
//   o_row_data       out  packed row, column c at [c*DATA_W +: DATA_W]
//   o_row_idx        out  memory row index of o_row_data
//   o_busy           out  load in progress
//   o_load_done      out  one-cycle pulse after the last row is accepted

module weight_mem_reader
    import tpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_preload_done,
    input  logic              i_start,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-1:0] o_mem_rd_addr,
    input  logic [DATA_W-1:0] i_mem_rd_data,
    output logic              o_row_valid,
    input  logic              i_row_ready,
    output logic [ROW_W-1:0]  o_row_data,
    output logic [IDX_W-1:0]  o_row_idx,
    output logic              o_busy,
    output logic              o_load_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

    wmr_state_t       r_state;
    wmr_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_row;
    logic [IDX_W-1:0] w_row_nxt;
    logic [IDX_W-1:0] r_col;
    logic [IDX_W-1:0] w_col_nxt;

    // Read pipeline: the column issued last cycle is the one whose data
    // arrives this cycle.
    logic             r_cap_en;
    logic [IDX_W-1:0] r_cap_col;

    logic             w_rd_en;
    logic             w_row_valid;
    logic             w_load_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= WMR_IDLE;
            r_row     <= '0;
            r_col     <= '0;
            r_cap_en  <= 1'b0;
            r_cap_col <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_row     <= w_row_nxt;
            r_col     <= w_col_nxt;
            r_cap_en  <= w_rd_en;
            r_cap_col <= r_col;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_rd_en     = 1'b0;
        w_row_valid = 1'b0;
        w_load_done = 1'b0;

        case (r_state)
            WMR_IDLE: begin
                if (i_start && i_preload_done) begin
                    w_state_nxt = WMR_FETCH;
                    w_row_nxt   = LAST_IDX;
                    w_col_nxt   = '0;
                end
            end

            WMR_FETCH: begin
                w_rd_en = 1'b1;
                if (!i_preload_done) begin
                    w_state_nxt = WMR_IDLE;
                    w_col_nxt   = '0;
                end else if (r_col == LAST_IDX) begin
                    w_state_nxt = WMR_DRAIN;
                    w_col_nxt   = '0;
                end else begin
                    w_col_nxt = r_col + IDX_W'(1);
                end
            end

            // One idle cycle so the last column's read data lands in the row.
            WMR_DRAIN: begin
                if (!i_preload_done) begin
                    w_state_nxt = WMR_IDLE;
                end else begin
                    w_state_nxt = WMR_HOLD;
                end
            end

            // Abort takes priority over a handshake in the same cycle.
            WMR_HOLD: begin
                w_row_valid = 1'b1;
                if (!i_preload_done) begin
                    w_state_nxt = WMR_IDLE;
                end else if (i_row_ready) begin
                    if (r_row == '0) begin
                        w_state_nxt = WMR_FINISH;
                    end else begin
                        w_row_nxt   = r_row - IDX_W'(1);
                        w_state_nxt = WMR_FETCH;
                    end
                end
            end

            WMR_FINISH: begin
                w_load_done = 1'b1;
                w_state_nxt = WMR_IDLE;
            end

            default: begin
                w_state_nxt = WMR_IDLE;
            end
        endcase
    end

    row_assembler u_row_assembler (
        .clk      (clk),
        .rst      (rst),
        .i_cap_en (r_cap_en),
        .i_col    (r_cap_col),
        .i_data   (i_mem_rd_data),
        .o_row    (o_row_data)
    );

    assign o_mem_rd_en   = w_rd_en;
    assign o_mem_rd_addr = ADDR_W'(r_row) * ADDR_W'(SIZE) + ADDR_W'(r_col);
    assign o_row_valid   = w_row_valid;
    assign o_row_idx     = r_row;
    assign o_busy        = (r_state != WMR_IDLE);
    assign o_load_done   = w_load_done;

endmodule

// File: tb/tb_weight_mem_reader.sv
// tb/tb_weight_mem_reader.sv - scoreboard bench for weight_mem_reader

module tb_weight_mem_reader;
    import tpu_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              preload_done;
    logic              start;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              row_valid;
    logic              row_ready;
    logic [ROW_W-1:0]  row_data;
    logic [IDX_W-1:0]  row_idx;
    logic              busy;
    logic              load_done;

    weight_mem_reader dut (
        .clk            (clk),
        .rst            (rst),
        .i_preload_done (preload_done),
        .i_start        (start),
        .o_mem_rd_en    (mem_rd_en),
        .o_mem_rd_addr  (mem_rd_addr),
        .i_mem_rd_data  (mem_rd_data),
        .o_row_valid    (row_valid),
        .i_row_ready    (row_ready),
        .o_row_data     (row_data),
        .o_row_idx      (row_idx),
        .o_busy         (busy),
        .o_load_done    (load_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [ROW_W-1:0] data;
        int               cyc;
    } row_exp_t;

    row_exp_t row_q[$];
    int       done_q[$];

    int n_cmp    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int rd_cnt   = 0;
    int hs_cnt   = 0;
    int done_cnt = 0;

    logic [DATA_W-1:0] mem [SIZE*SIZE];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: one-cycle registered read.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= mem[mem_rd_addr];
            rd_cnt      <= rd_cnt + 1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected packed row r for mem[i] = i % 32.
    function automatic logic [ROW_W-1:0] exp_row(input int r);
        logic [ROW_W-1:0] v;
        v = '0;
        for (int c = 0; c < SIZE; c++) begin
            v[c*DATA_W +: DATA_W] = DATA_W'((r * SIZE + c) % 32);
        end
        return v;
    endfunction

    // Monitor: pops expectations whenever the DUT presents a handshake or done pulse.
    always @(negedge clk) begin
        row_exp_t e;
        if (!rst && row_valid && row_ready) begin
            hs_cnt++;
            chk("sb_row_pending", (row_q.size() > 0), 1);
            if (row_q.size() > 0) begin
                e = row_q.pop_front();
                chk("row_idx", row_idx, e.idx);
                chk("row_data", row_data, e.data);
                chk("row_cycle", cyc, e.cyc);
            end
        end
        if (load_done) begin
            done_cnt++;
            chk("sb_done_pending", (done_q.size() > 0), 1);
            if (done_q.size() > 0) chk("load_done_cycle", cyc, done_q.pop_front());
        end
        if (mem_rd_en) chk("rd_en_only_when_busy", busy, 1);
    end

    // mode: 0 normal, 1 stall at row 4, 2 start while busy, 3 preload abort, 4 reset mid-HOLD
    task automatic run_load(input int mode);
        int c0, hs0, rd0, dn0, rd_stall, n_rows, exp_rd;
        int stall_add;
        @(posedge clk); #1;
        start = 1'b1;
        row_ready = 1'b1;
        c0  = cyc;
        hs0 = hs_cnt;
        rd0 = rd_cnt;
        dn0 = done_cnt;
        n_rows = (mode == 3) ? 2 : (mode == 4) ? 3 : SIZE;
        for (int i = 0; i < n_rows; i++) begin
            row_exp_t e;
            int r;
            r = SIZE - 1 - i;
            stall_add = (mode == 1 && r <= 4) ? 5 : 0;
            e.idx  = IDX_W'(r);
            e.data = exp_row(r);
            e.cyc  = c0 + 10 + 10 * i + stall_add;
            row_q.push_back(e);
        end
        if (mode <= 2) done_q.push_back(c0 + 81 + ((mode == 1) ? 5 : 0));
        @(negedge clk);
        chk("busy_before_accept", busy, 0);
        rd_stall = 0;
        for (int k = 1; k <= 90; k++) begin
            @(posedge clk); #1;
            start     = (mode == 2) && (k == 3 || k == 40);
            row_ready = !(mode == 1 && k >= 40 && k <= 44);
            if (mode == 3 && k == 23) preload_done = 1'b0;
            if (mode == 4 && k == 40) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_row_valid", row_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_rd_en", mem_rd_en, 0);
                chk("rst_row_data", row_data, 0);
                chk("rst_row_idx", row_idx, 0);
                chk("rst_addr", mem_rd_addr, 0);
                chk("rst_load_done", load_done, 0);
                @(posedge clk); #1;
                @(posedge clk); #1;
                rst = 1'b0;
                break;
            end
            @(negedge clk);
            if (k == 1) chk("busy_after_accept", busy, 1);
            if (mode == 0 && k == 9) chk("row_valid_not_early", row_valid, 0);
            if (mode == 0 && k == 10) chk("row7_first_seen", row_valid, 1);
            if (mode == 1 && k == 40) rd_stall = rd_cnt;
            if (mode == 1 && k >= 40 && k <= 44) begin
                chk("stall_valid", row_valid, 1);
                chk("stall_idx", row_idx, 4);
                chk("stall_data", row_data, exp_row(4));
                chk("stall_rd_en", mem_rd_en, 0);
                chk("stall_rd_cnt", rd_cnt, rd_stall);
            end
            if (mode == 3 && k == 24) begin
                chk("abort_busy", busy, 0);
                chk("abort_rd_en", mem_rd_en, 0);
                chk("abort_valid", row_valid, 0);
            end
            if (mode == 3 && k == 40) break;
        end
        preload_done = 1'b1;
        start        = 1'b0;
        row_ready    = 1'b1;
        exp_rd = (mode == 3) ? 19 : (mode == 4) ? 32 : SIZE * SIZE;
        chk("rows_left", row_q.size(), 0);
        chk("done_left", done_q.size(), 0);
        chk("handshakes", hs_cnt - hs0, n_rows);
        chk("load_done_count", done_cnt - dn0, (mode <= 2) ? 1 : 0);
        chk("read_count", rd_cnt - rd0, exp_rd);
        chk("idle_after", busy, 0);
    endtask

    initial begin
        int rd0;
        for (int i = 0; i < SIZE * SIZE; i++) mem[i] = DATA_W'(i % 32);
        rst          = 1'b1;
        preload_done = 1'b0;
        start        = 1'b0;
        row_ready    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", row_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rd_en", mem_rd_en, 0);
        chk("reset_data", row_data, 0);
        chk("reset_idx", row_idx, 0);
        chk("reset_done", load_done, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // start without preload_done is ignored
        @(posedge clk); #1;
        rd0   = rd_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) begin
            @(negedge clk);
            chk("no_preload_busy", busy, 0);
        end
        chk("no_preload_reads", rd_cnt - rd0, 0);
        preload_done = 1'b1;

        run_load(0);
        run_load(1);
        run_load(2);
        run_load(3);
        run_load(4);
        run_load(0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
